// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 1280x1024@60 raster constants shared by the VGA timing blocks
package vga_timing_pkg;
  localparam int COORD_W = 12;
  localparam int COORD_LIMIT = 1 << COORD_W;
  localparam int DEF_H_VIS = 1280;
  localparam int DEF_H_FP = 48;
  localparam int DEF_H_SYNC = 112;
  localparam int DEF_H_BP = 248;
  localparam int DEF_V_VIS = 1024;
  localparam int DEF_V_FP = 1;
  localparam int DEF_V_SYNC = 3;
  localparam int DEF_V_BP = 38;
  localparam int H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;
  localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter with wrap flag and combinational sync/visible decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = H_TOTAL,
  parameter int VIS = DEF_H_VIS,
  parameter int SYNC_START = H_SYNC_START,
  parameter int SYNC_W = DEF_H_SYNC,
  parameter bit POL = 1'b1
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               sync,
  output logic               visible
);
  localparam logic [COORD_W:0] LAST = (COORD_W + 1)'(TOTAL - 1);
  localparam logic [COORD_W:0] VIS_X = (COORD_W + 1)'(VIS);
  localparam logic [COORD_W:0] S0 = (COORD_W + 1)'(SYNC_START);
  localparam logic [COORD_W:0] S1 = (COORD_W + 1)'(SYNC_START + SYNC_W);
  logic [COORD_W-1:0] cnt_q, cnt_d;
  logic [COORD_W:0] cnt_x;
  always_comb begin
    cnt_x = {1'b0, cnt_q};
    wrap = cnt_x == LAST;
    cnt_d = en ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
    sync = (cnt_x >= S0 && cnt_x < S1) ? POL : ~POL;
    visible = cnt_x < VIS_X;
  end
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign count = cnt_q;
endmodule

// File: rtl/vga_coord_generator.sv
// vga_coord_generator: free-running VGA raster generator with registered coords, syncs and frame counter
module vga_coord_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VIS = DEF_H_VIS,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_VIS = DEF_V_VIS,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit H_POL = 1'b1,
  parameter bit V_POL = 1'b1
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               PIX_EN,
  output logic [COORD_W-1:0] VGA_horzCoord,
  output logic [COORD_W-1:0] VGA_vertCoord,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_active,
  output logic               FRAME_START,
  output logic [15:0]        FRAME_CNT
);
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  if (HT > COORD_LIMIT || VT > COORD_LIMIT) begin : g_bad_cfg
    $error("vga_coord_generator: line or frame total exceeds the 12-bit coordinate range");
  end
  logic [COORD_W-1:0] hcnt, vcnt;
  logic h_wrap, v_wrap, h_sync, v_sync, h_vis, v_vis;
  vga_axis_counter #(
    .TOTAL(HT), .VIS(H_VIS), .SYNC_START(H_VIS + H_FP), .SYNC_W(H_SYNC), .POL(H_POL)
  ) u_h (
    .CLK(CLK), .RESETN(RESETN), .en(PIX_EN),
    .count(hcnt), .wrap(h_wrap), .sync(h_sync), .visible(h_vis)
  );
  vga_axis_counter #(
    .TOTAL(VT), .VIS(V_VIS), .SYNC_START(V_VIS + V_FP), .SYNC_W(V_SYNC), .POL(V_POL)
  ) u_v (
    .CLK(CLK), .RESETN(RESETN), .en(PIX_EN & h_wrap),
    .count(vcnt), .wrap(v_wrap), .sync(v_sync), .visible(v_vis)
  );
  logic [COORD_W-1:0] horz_q, horz_d, vert_q, vert_d;
  logic hs_q, hs_d, vs_q, vs_d, active_q, active_d, fs_q, fs_d, origin_q, origin_d;
  logic [15:0] fcnt_q, fcnt_d;
  // origin_q marks that the counters sit at (0,0), i.e. the last enabled edge closed a frame
  always_comb begin
    horz_d = PIX_EN ? hcnt : horz_q;
    vert_d = PIX_EN ? vcnt : vert_q;
    hs_d = PIX_EN ? h_sync : hs_q;
    vs_d = PIX_EN ? v_sync : vs_q;
    active_d = PIX_EN ? (h_vis & v_vis) : active_q;
    fs_d = PIX_EN ? origin_q : fs_q;
    origin_d = PIX_EN ? (h_wrap & v_wrap) : origin_q;
    fcnt_d = (PIX_EN && origin_q) ? fcnt_q + 16'd1 : fcnt_q;
  end
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      horz_q <= '0;
      vert_q <= '0;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      active_q <= 1'b0;
      fs_q <= 1'b0;
      origin_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      horz_q <= horz_d;
      vert_q <= vert_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      active_q <= active_d;
      fs_q <= fs_d;
      origin_q <= origin_d;
      fcnt_q <= fcnt_d;
    end
  assign VGA_horzCoord = horz_q;
  assign VGA_vertCoord = vert_q;
  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;
  assign VGA_active = active_q;
  assign FRAME_START = fs_q;
  assign FRAME_CNT = fcnt_q;
endmodule

// File: tb/tb_vga_coord_generator.sv
// tb_vga_coord_generator: directed checks of a default-timing and a reduced-timing raster generator
module tb_vga_coord_generator;
  logic clk = 1'b0;
  logic rst_n_a = 1'b0, en_a = 1'b1, rst_n_b = 1'b0, en_b = 1'b0;
  logic [11:0] ha, va, hb, vb;
  logic hs_a, vs_a, act_a, fs_a, hs_b, vs_b, act_b, fs_b;
  logic [15:0] fc_a, fc_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  vga_coord_generator u_a (
    .CLK(clk), .RESETN(rst_n_a), .PIX_EN(en_a),
    .VGA_horzCoord(ha), .VGA_vertCoord(va), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .VGA_active(act_a), .FRAME_START(fs_a), .FRAME_CNT(fc_a)
  );
  vga_coord_generator #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .H_POL(1'b0), .V_POL(1'b1)
  ) u_b (
    .CLK(clk), .RESETN(rst_n_b), .PIX_EN(en_b),
    .VGA_horzCoord(hb), .VGA_vertCoord(vb), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_active(act_b), .FRAME_START(fs_b), .FRAME_CNT(fc_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int bad, hs_n, fs_n, vs_n, f1, f2;
    logic [11:0] eh, ev;
    repeat (2) @(negedge clk);
    chk("a_rst_coord", {ha, va}, 0);
    chk("a_rst_bits", {hs_a, vs_a, act_a, fs_a}, 4'b0000);
    chk("a_rst_fcnt", fc_a, 0);
    chk("b_rst_bits", {hs_b, vs_b, act_b, fs_b}, 4'b1000);
    rst_n_a = 1'b1;
    bad = 0; hs_n = 0; fs_n = 0;
    for (int n = 1; n <= 1689; n++) begin
      step();
      eh = 12'((n - 1) % 1688);
      ev = 12'((n - 1) / 1688);
      if ({ha, va} !== {eh, ev}) bad++;
      hs_n += int'(hs_a);
      fs_n += int'(fs_a);
      if (n == 1) begin
        chk("a_first_coord", {ha, va}, 0);
        chk("a_first_flags", {act_a, fs_a}, 2'b11);
        chk("a_first_fcnt", fc_a, 1);
      end
      if (eh == 12'd1279 && ev == 12'd0) chk("a_act_1279", act_a, 1);
      if (eh == 12'd1280) chk("a_act_1280", {ha, act_a}, {12'd1280, 1'b0});
      if (eh == 12'd1327) chk("a_hs_1327", hs_a, 0);
      if (eh == 12'd1328) chk("a_hs_1328", hs_a, 1);
      if (eh == 12'd1439) chk("a_hs_1439", hs_a, 1);
      if (eh == 12'd1440) chk("a_hs_1440", hs_a, 0);
      if (n == 1689) chk("a_line2", {ha, va, vs_a}, {12'd0, 12'd1, 1'b0});
    end
    chk("a_coord_seq", bad, 0);
    chk("a_hs_width", hs_n, 112);
    chk("a_fs_once", fs_n, 1);
    repeat (700) step();
    chk("a_pre_rst", {ha, va}, {12'd700, 12'd1});
    #2 rst_n_a = 1'b0;
    #1;
    chk("a_async_coord", {ha, va}, 0);
    chk("a_async_bits", {hs_a, vs_a, act_a, fs_a}, 4'b0000);
    chk("a_async_fcnt", fc_a, 0);
    @(negedge clk);
    rst_n_a = 1'b1;
    step();
    chk("a_restart", {ha, va, act_a, fs_a}, {12'd0, 12'd0, 1'b1, 1'b1});
    chk("a_restart_fcnt", fc_a, 1);
    rst_n_b = 1'b1;
    en_b = 1'b1;
    bad = 0; fs_n = 0; vs_n = 0; f1 = 0; f2 = 0;
    for (int n = 1; n <= 290; n++) begin
      int idx, h, v;
      logic [36:0] expv;
      step();
      idx = n - 1;
      h = idx % 16;
      v = (idx / 16) % 9;
      expv = {12'(h), 12'(v), !(h >= 10 && h <= 12), (v >= 5 && v <= 6),
              (h < 8 && v < 4), (h == 0 && v == 0), 16'(idx / 144 + 1)};
      if ({hb, vb, hs_b, vs_b, act_b, fs_b, fc_b} !== expv) bad++;
      if (fs_b) begin
        fs_n++;
        if (fs_n == 1) f1 = n;
        else if (fs_n == 2) f2 = n;
      end
      if (n <= 144 && vs_b) vs_n++;
      if (n == 144) chk("b_last", {hb, vb, fs_b}, {12'd15, 12'd8, 1'b0});
      if (n == 145) begin
        chk("b_wrap", {hb, vb, fs_b}, {12'd0, 12'd0, 1'b1});
        chk("b_wrap_fcnt", fc_b, 2);
      end
    end
    chk("b_seq", bad, 0);
    chk("b_fs_gap", f2 - f1, 144);
    chk("b_fs_count", fs_n, 3);
    chk("b_vs_width", vs_n, 32);
    step();
    chk("b_en1", hb, 2);
    en_b = 1'b0;
    step();
    chk("b_hold1", hb, 2);
    step();
    chk("b_hold2", hb, 2);
    en_b = 1'b1;
    step();
    chk("b_resume", hb, 3);
    for (int k = 0; k < 200 && !fs_b; k++) step();
    chk("b_fs_found", {hb, vb, fs_b}, {12'd0, 12'd0, 1'b1});
    chk("b_fs_fcnt", fc_b, 4);
    en_b = 1'b0;
    repeat (3) step();
    chk("b_origin_hold", {hb, fs_b}, {12'd0, 1'b1});
    chk("b_origin_fcnt", fc_b, 4);
    en_b = 1'b1;
    step();
    chk("b_origin_leave", {hb, fs_b}, {12'd1, 1'b0});
    chk("b_origin_leave_fcnt", fc_b, 4);
    en_b = 1'b0;
    force u_b.fcnt_q = 16'hFFFF;
    step();
    release u_b.fcnt_q;
    #1;
    chk("b_force", fc_b, 16'hFFFF);
    @(negedge clk);
    en_b = 1'b1;
    for (int k = 0; k < 200 && !fs_b; k++) step();
    chk("b_fcnt_wrap", {fs_b, fc_b}, {1'b1, 16'h0000});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
